monster_collision_dir_gen: RTL and testbench

- Upstream stage of the random-walk monster motion FSM. Produces its four steering inputs: `monsterCollision`, a 2-bit collision-side code, `random_move` and `oneSecPulse`.
- Classifies the first monster/wall pixel overlap in each frame by the nearest sprite edge, and reports it as a single one-cycle pulse.
- Divides `startOfFrame` down to a once-per-second pulse, and supplies an LFSR-driven direction for that pulse.

---
 rtl/monster_pkg.sv | 40 ++++
 rtl/monster_collision_dir_gen_if.sv | 50 +++++
 rtl/monster_collision_dir_gen_lfsr16.sv | 46 ++++
 rtl/monster_collision_dir_gen.sv | 189 ++++++++++++++++++
 tb/tb_monster_collision_dir_gen.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/monster_pkg.sv
// -----------------------------------------------------------------------------
// monster_pkg
// Shared definitions for the monster motion path: collision-side codes,
// random-walk direction codes, the collision FSM state type and the default
// sprite / timing parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package monster_pkg;

    // Default sprite edge length in pixels (power of two).
    localparam int          OBJECT_SIZE_DEF    = 32;
    // Default number of startOfFrame pulses per oneSecPulse.
    localparam int          FRAMES_PER_SEC_DEF = 30;
    // Default LFSR reset / reload value (must be non-zero).
    localparam logic [15:0] LFSR_SEED_DEF      = 16'hACE1;

    // Side of the sprite that touched the wall.
    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } coll_dir_e;

    // Random-walk direction handed to the motion FSM.
    typedef enum logic [1:0] {
        MOVE_RIGHT = 2'd0,
        MOVE_DOWN  = 2'd1,
        MOVE_LEFT  = 2'd2,
        MOVE_UP    = 2'd3
    } move_dir_e;

    // Collision reporting FSM.
    typedef enum logic [1:0] {
        IDLE_ST  = 2'd0,
        ARMED_ST = 2'd1,
        HIT_ST   = 2'd2
    } coll_state_e;

endpackage

// File: rtl/monster_collision_dir_gen_if.sv
// -----------------------------------------------------------------------------
// monster_collision_dir_gen_if
// Groups the per-pixel inputs and the steering outputs of
// monster_collision_dir_gen.
//   master : the video/game side, drives frame, pixel and sprite position,
//            receives the steering outputs.
//   slave  : monster_collision_dir_gen itself.
// Signals:
//   startOfFrame            one-cycle pulse at frame start
//   playGame                game-running enable
//   drawing_request_monster current pixel is a monster pixel
//   drawing_request_wall    current pixel is a wall pixel
//   pixelX / pixelY         current pixel column / row (signed 11 bit)
//   monsterTopLeftX/Y       monster top-left corner (signed 11 bit)
//   monsterCollision        one-cycle collision pulse, at most one per frame
//   collision_direction     hit side: 00 right, 01 left, 10 down, 11 up
//   random_move             random direction: 0 right, 1 down, 2 left, 3 up
//   oneSecPulse             one-cycle pulse once per second of frames
// -----------------------------------------------------------------------------
interface monster_collision_dir_gen_if;

    logic               startOfFrame;
    logic               playGame;
    logic               drawing_request_monster;
    logic               drawing_request_wall;
    logic signed [10:0] pixelX;
    logic signed [10:0] pixelY;
    logic signed [10:0] monsterTopLeftX;
    logic signed [10:0] monsterTopLeftY;

    logic               monsterCollision;
    logic [1:0]         collision_direction;
    logic [1:0]         random_move;
    logic               oneSecPulse;

    modport master (
        output startOfFrame, playGame,
        output drawing_request_monster, drawing_request_wall,
        output pixelX, pixelY, monsterTopLeftX, monsterTopLeftY,
        input  monsterCollision, collision_direction, random_move, oneSecPulse
    );

    modport slave (
        input  startOfFrame, playGame,
        input  drawing_request_monster, drawing_request_wall,
        input  pixelX, pixelY, monsterTopLeftX, monsterTopLeftY,
        output monsterCollision, collision_direction, random_move, oneSecPulse
    );

endinterface

// File: rtl/monster_collision_dir_gen_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR, shifts left every clock, taps 16/14/13/11
// (feedback = q[15]^q[13]^q[12]^q[10]). Loads `seed` on reset and reloads it
// if the register is ever found at zero, so the sequence cannot lock up.
// Ports:
//   clk     system clock
//   resetN  asynchronous active-low reset
//   seed    non-zero reset / reload value
//   q       current LFSR contents
// -----------------------------------------------------------------------------
module lfsr16 (
    input  logic        clk,
    input  logic        resetN,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = {lfsr_q[14:0], feedback};
        if (lfsr_q == 16'h0000) begin
            lfsr_d = seed;
        end
    end

    // NOTE: state registers use non-blocking assignments only, with the
    // asynchronous active-low reset in the sensitivity list, so all flops
    // update together on the edge regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/monster_collision_dir_gen.sv
// -----------------------------------------------------------------------------
// monster_collision_dir_gen
// Upstream stage of the random-walk monster motion FSM.
//  * Detects the first monster/wall pixel overlap of each frame, classifies it
//    by the nearest sprite edge and reports it as a single one-cycle
//    monsterCollision pulse with a held collision_direction code.
//  * Divides startOfFrame down to a once-per-second oneSecPulse.
//  * Samples an LFSR into random_move on every startOfFrame.
// Ports:
//   clk     system clock
//   resetN  asynchronous active-low reset
//   bus     monster_collision_dir_gen_if.slave (pixel inputs, steering outputs)
// -----------------------------------------------------------------------------
module monster_collision_dir_gen
    import monster_pkg::*;
#(
    parameter int          OBJECT_SIZE    = OBJECT_SIZE_DEF,
    parameter int          FRAMES_PER_SEC = FRAMES_PER_SEC_DEF,
    parameter logic [15:0] LFSR_SEED      = LFSR_SEED_DEF
) (
    input  logic                         clk,
    input  logic                         resetN,
    monster_collision_dir_gen_if.slave   bus
);

    localparam int OFF_W = $clog2(OBJECT_SIZE);
    localparam int CNT_W = $clog2(FRAMES_PER_SEC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_SEC - 1);

    // ------------------------------------------------------------------
    // Side classification
    // ------------------------------------------------------------------
    logic               overlap;
    logic signed [10:0] off_x;
    logic signed [10:0] off_y;
    logic [OFF_W-1:0]   d_l;
    logic [OFF_W-1:0]   d_r;
    logic [OFF_W-1:0]   d_t;
    logic [OFF_W-1:0]   d_b;
    coll_dir_e          side;

    always_comb begin
        overlap = bus.drawing_request_monster & bus.drawing_request_wall;
        off_x   = bus.pixelX - bus.monsterTopLeftX;
        off_y   = bus.pixelY - bus.monsterTopLeftY;
        // Only the position inside the sprite matters; with a power-of-two
        // size, OBJECT_SIZE-1-off is simply the bitwise complement.
        d_l     = off_x[OFF_W-1:0];
        d_r     = ~off_x[OFF_W-1:0];
        d_t     = off_y[OFF_W-1:0];
        d_b     = ~off_y[OFF_W-1:0];

        // Nearest edge wins; the test order gives ties to up, down, left.
        if ((d_t <= d_b) && (d_t <= d_l) && (d_t <= d_r)) begin
            side = DIR_UP;
        end else if ((d_b <= d_l) && (d_b <= d_r)) begin
            side = DIR_DOWN;
        end else if (d_l <= d_r) begin
            side = DIR_LEFT;
        end else begin
            side = DIR_RIGHT;
        end
    end

    // ------------------------------------------------------------------
    // Collision FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    coll_state_e state_q;
    coll_state_e state_d;
    logic        hit_q;
    logic        hit_d;
    coll_dir_e   dir_q;
    coll_dir_e   dir_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE_ST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE_ST:  if (bus.playGame)     state_d = ARMED_ST;
            // An overlap in the frame-start cycle still counts here.
            ARMED_ST: if (overlap)          state_d = HIT_ST;
            // Re-arm on frame start; an overlap in that same cycle is dropped.
            HIT_ST:   if (bus.startOfFrame) state_d = ARMED_ST;
            default:                        state_d = IDLE_ST;
        endcase
        if (!bus.playGame) begin
            state_d = IDLE_ST;
        end
    end

    always_comb begin
        hit_d = (state_q == ARMED_ST) && overlap && bus.playGame;
        dir_d = hit_d ? side : dir_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_q <= 1'b0;
            dir_q <= DIR_RIGHT;
        end else begin
            hit_q <= hit_d;
            dir_q <= dir_d;
        end
    end

    // A registered hit is suppressed in any cycle where the game is stopped.
    assign bus.monsterCollision    = hit_q & bus.playGame;
    assign bus.collision_direction = dir_q;

    // ------------------------------------------------------------------
    // Frame-to-second divider
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] frame_cnt_d;
    logic             sec_q;
    logic             sec_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        sec_d       = 1'b0;
        if (!bus.playGame) begin
            frame_cnt_d = '0;
        end else if (bus.startOfFrame) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                sec_d       = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt_q <= '0;
            sec_q       <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            sec_q       <= sec_d;
        end
    end

    assign bus.oneSecPulse = sec_q;

    // ------------------------------------------------------------------
    // Random direction
    // ------------------------------------------------------------------
    logic [15:0] lfsr_q;
    move_dir_e   random_move_q;
    move_dir_e   random_move_d;

    lfsr16 u_lfsr (
        .clk    (clk),
        .resetN (resetN),
        .seed   (LFSR_SEED),
        .q      (lfsr_q)
    );

    // Sampled on every frame start, so it is already settled and constant
    // in the cycle oneSecPulse is high.
    always_comb begin
        random_move_d = random_move_q;
        if (bus.startOfFrame) begin
            random_move_d = move_dir_e'(lfsr_q[1:0]);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            random_move_q <= MOVE_RIGHT;
        end else begin
            random_move_q <= random_move_d;
        end
    end

    assign bus.random_move = random_move_q;

    // Bits deliberately left unused (sprite-external offset bits, LFSR body).
    logic unused_bits;
    assign unused_bits = ^{off_x[10:OFF_W], off_y[10:OFF_W], lfsr_q[15:2]};

endmodule

// File: tb/tb_monster_collision_dir_gen.sv
// -----------------------------------------------------------------------------
// tb_monster_collision_dir_gen
// Directed bench for monster_collision_dir_gen: reset values, second divider,
// edge classification with tie priority, once-per-frame reporting, frame-start
// coincidences, playGame gating and asynchronous mid-run reset. A reference
// LFSR tracks the expected random_move value on every cycle.
// -----------------------------------------------------------------------------
module tb_monster_collision_dir_gen;

    logic clk = 1'b0;
    logic resetN;

    always #5 clk = ~clk;

    monster_collision_dir_gen_if bus ();

    monster_collision_dir_gen #(
        .OBJECT_SIZE    (32),
        .FRAMES_PER_SEC (30),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR and expected random_move.
    logic [15:0] m_lfsr;
    logic [1:0]  m_rm;
    int          rm_viol   = 0;
    int          lfsr_zero = 0;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_lfsr <= 16'hACE1;
            m_rm   <= 2'd0;
        end else begin
            if (bus.startOfFrame) m_rm <= m_lfsr[1:0];
            if (m_lfsr == 16'h0000) m_lfsr <= 16'hACE1;
            else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    always @(negedge clk) begin
        if (bus.random_move !== m_rm) rm_viol <= rm_viol + 1;
        if (dut.lfsr_q == 16'h0000) lfsr_zero <= lfsr_zero + 1;
    end

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof_cycle();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic set_overlap(input int x, input int y);
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        bus.drawing_request_monster = 1'b1;
        bus.drawing_request_wall    = 1'b1;
    endtask

    task automatic clr_overlap();
        bus.drawing_request_monster = 1'b0;
        bus.drawing_request_wall    = 1'b0;
    endtask

    task automatic hit_at(input int x, input int y);
        set_overlap(x, y);
        tick();
        clr_overlap();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    int pulses;

    initial begin
        resetN = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.playGame = 1'b0;
        bus.drawing_request_monster = 1'b0;
        bus.drawing_request_wall = 1'b0;
        bus.pixelX = '0;
        bus.pixelY = '0;
        bus.monsterTopLeftX = 11'sd400;
        bus.monsterTopLeftY = 11'sd330;

        // Reset values
        tick();
        tick();
        check("rst_coll", bus.monsterCollision, 0);
        check("rst_dir", bus.collision_direction, 0);
        check("rst_rm", bus.random_move, 0);
        check("rst_sec", bus.oneSecPulse, 0);

        // Second divider: 95 frames -> pulses after frames 30, 60, 90
        resetN = 1'b1;
        bus.playGame = 1'b1;
        tick();
        pulses = 0;
        for (int i = 1; i <= 95; i++) begin
            sof_cycle();
            check($sformatf("sec_f%0d", i), bus.oneSecPulse, (i % 30) == 0);
            if (bus.oneSecPulse) pulses = pulses + 1;
            tick();
            check($sformatf("sec_len_f%0d", i), bus.oneSecPulse, 0);
            tick();
            tick();
        end
        check("sec_count", pulses, 3);

        // Right edge: offX = 31
        hit_at(431, 345);
        check("right_coll", bus.monsterCollision, 1);
        check("right_dir", bus.collision_direction, 2'b00);
        tick();
        check("right_len", bus.monsterCollision, 0);

        // Same frame: further overlaps ignored
        hit_at(400, 330);
        check("ign1_coll", bus.monsterCollision, 0);
        hit_at(415, 361);
        check("ign2_coll", bus.monsterCollision, 0);
        hit_at(401, 340);
        check("ign3_coll", bus.monsterCollision, 0);
        check("ign_dir", bus.collision_direction, 2'b00);

        // Top edge: offY = 0
        sof_cycle();
        hit_at(410, 330);
        check("up_coll", bus.monsterCollision, 1);
        check("up_dir", bus.collision_direction, 2'b11);
        tick();

        // Left edge: offX = 0, offY = 15
        sof_cycle();
        hit_at(400, 345);
        check("left_coll", bus.monsterCollision, 1);
        check("left_dir", bus.collision_direction, 2'b01);
        tick();

        // Bottom edge: offY = 31
        sof_cycle();
        hit_at(415, 361);
        check("down_coll", bus.monsterCollision, 1);
        check("down_dir", bus.collision_direction, 2'b10);
        tick();

        // Corner tie dT = dL = 0 -> up
        sof_cycle();
        hit_at(400, 330);
        check("tie_coll", bus.monsterCollision, 1);
        check("tie_dir", bus.collision_direction, 2'b11);
        tick();

        // Overlap coincident with frame start in HIT_ST: ignored
        bus.startOfFrame = 1'b1;
        hit_at(400, 345);
        bus.startOfFrame = 1'b0;
        check("hit_sof_coll", bus.monsterCollision, 0);
        check("hit_sof_dir", bus.collision_direction, 2'b11);

        // Overlap coincident with frame start in ARMED_ST: reported
        bus.startOfFrame = 1'b1;
        hit_at(400, 345);
        bus.startOfFrame = 1'b0;
        check("arm_sof_coll", bus.monsterCollision, 1);
        check("arm_sof_dir", bus.collision_direction, 2'b01);
        tick();
        check("arm_sof_len", bus.monsterCollision, 0);

        // playGame low: overlap ignored, direction held
        bus.playGame = 1'b0;
        tick();
        hit_at(431, 345);
        check("idle_coll", bus.monsterCollision, 0);
        check("idle_dir", bus.collision_direction, 2'b01);
        sof_cycle();
        check("idle_sec", bus.oneSecPulse, 0);

        // Re-enable: armed again, right-edge hit reported
        bus.playGame = 1'b1;
        tick();
        hit_at(431, 345);
        check("rearm_coll", bus.monsterCollision, 1);
        check("rearm_dir", bus.collision_direction, 2'b00);
        tick();

        // Pulse registered, then playGame dropped in the output cycle
        sof_cycle();
        hit_at(415, 361);
        bus.playGame = 1'b0;
        #1;
        check("force0_coll", bus.monsterCollision, 0);
        tick();
        bus.playGame = 1'b1;
        tick();

        // Counter restart: 20 frames, playGame drop, then 30 fresh frames
        bus.playGame = 1'b0;
        tick();
        bus.playGame = 1'b1;
        tick();
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            sof_cycle();
            if (bus.oneSecPulse) pulses = pulses + 1;
            tick();
        end
        check("pre_drop_sec", pulses, 0);
        tick();
        bus.playGame = 1'b0;
        tick();
        tick();
        bus.playGame = 1'b1;
        tick();
        pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            sof_cycle();
            if (i == 10) check("restart_f10", bus.oneSecPulse, 0);
            if (i == 30) check("restart_f30", bus.oneSecPulse, 1);
            if (bus.oneSecPulse) pulses = pulses + 1;
            tick();
        end
        check("restart_count", pulses, 1);

        // Asynchronous reset while a collision pulse is high
        sof_cycle();
        hit_at(431, 345);
        check("pre_rst_coll", bus.monsterCollision, 1);
        resetN = 1'b0;
        #1;
        check("mid_rst_coll", bus.monsterCollision, 0);
        check("mid_rst_dir", bus.collision_direction, 0);
        check("mid_rst_rm", bus.random_move, 0);
        check("mid_rst_sec", bus.oneSecPulse, 0);
        tick();
        resetN = 1'b1;
        tick();
        check("post_rst_coll", bus.monsterCollision, 0);
        check("post_rst_sec", bus.oneSecPulse, 0);
        tick();

        // random_move tracked its reference every cycle; LFSR never zero
        check("rm_track", rm_viol, 0);
        check("lfsr_nonzero", lfsr_zero, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
